// File: rtl/cc1200_spi_pkg.sv
// cc1200_spi_pkg: shared types and constants for the CC1200 SPI master.
//   spi_state_t   : FSM state encoding (ST_RDY_WAIT exists only with
//                   CC1200_CHIP_RDY_WAIT_EN defined)
//   MAX_BYTES     : largest transfer length in bytes
//   *_DEF         : default chip-select timing and ready-wait timeout
//   ABORT_DATA    : DataIn value reported after a ready-wait timeout
//   clamp_bytes() : WR -> byte count (values above MAX_BYTES clamp)
//   align_tx()    : left-justify the N-byte transmit word so bit 31 goes first
package cc1200_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS_SETUP,
`ifdef CC1200_CHIP_RDY_WAIT_EN
      ST_RDY_WAIT,
`endif
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_CS_HOLD
   } spi_state_t;

   localparam int          MAX_BYTES       = 4;
   localparam int          CS_LEAD_DEF     = 2;
   localparam int          CS_TRAIL_DEF    = 2;
   localparam int          RDY_TIMEOUT_DEF = 4096;
   localparam logic [31:0] ABORT_DATA      = 32'hFFFF_FFFF;

   function automatic logic [2:0] clamp_bytes(input logic [3:0] wr);
      return (wr > 4'(MAX_BYTES)) ? 3'(MAX_BYTES) : wr[2:0];
   endfunction

   function automatic logic [31:0] align_tx(input logic [31:0] d, input logic [2:0] n);
      logic [31:0] r;
      case (n)
         3'd1:    r = {d[7:0], 24'h0};
         3'd2:    r = {d[15:0], 16'h0};
         3'd3:    r = {d[23:0], 8'h0};
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/cc1200_spi_clkgen.sv
// cc1200_spi_clkgen: SCLK half-period timer.
//   clk, rstn : system clock, async active-low reset
//   i_run     : FSM is in a shift phase
//   i_phase   : current SCLK level (0 = low half, 1 = high half)
//   i_div     : half-period reload value (half-period = i_div+1 cycles)
//   o_rise    : last cycle of the low half (SCLK rises next edge)
//   o_fall    : last cycle of the high half (SCLK falls next edge)
module cc1200_spi_clkgen
   import cc1200_spi_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        i_run,
   input  logic        i_phase,
   input  logic [15:0] i_div,
   output logic        o_rise,
   output logic        o_fall
);

   logic [15:0] r_cnt;
   logic        w_zero;

   assign w_zero = (r_cnt == 16'd0);

   // Reloads continuously while idle so the first half-period starts full.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         r_cnt <= 16'd0;
      else if (!i_run || w_zero)
         r_cnt <= i_div;
      else
         r_cnt <= r_cnt - 16'd1;
   end

   assign o_rise = i_run & ~i_phase & w_zero;
   assign o_fall = i_run &  i_phase & w_zero;

endmodule

// File: rtl/cc1200_spi_master.sv
// cc1200_spi_master: mode-0, MSB-first, 1-4 byte SPI master for the CC1200.
// Optional build macro CC1200_CHIP_RDY_WAIT_EN: wait for CHIP_RDYn (MISO low)
// after CS setup, aborting with DataIn = all ones after RDY_TIMEOUT cycles.
//   clk, rstn        : system clock, async active-low reset
//   Start            : request pulse, ignored while Busy or with WR = 0
//   DataOut/WR       : transmit word / byte count (clamped to 4)
//   ClockDiv         : SCLK half-period = ClockDiv+1 cycles
//   Trans            : keep CSn low after this transfer
//   Busy, DataIn     : status and last received word
//   SCLK, CSn, MOSI  : SPI outputs (all registered); MISO : SPI input
//
// state        | meaning
// IDLE         | waiting for Start; CSn may still be low from a burst
// CS_SETUP     | CSn low, CS_LEAD cycles before the first SCLK edge
// RDY_WAIT     | waiting for MISO low (CC1200_CHIP_RDY_WAIT_EN only)
// SHIFT_LO     | SCLK low half; MISO sampled on exit
// SHIFT_HI     | SCLK high half; MOSI advances on exit
// CS_HOLD      | CS_TRAIL cycles before CSn rises
module cc1200_spi_master
   import cc1200_spi_pkg::*;
#(
   parameter int CS_LEAD     = CS_LEAD_DEF,
   parameter int CS_TRAIL    = CS_TRAIL_DEF,
   parameter int RDY_TIMEOUT = RDY_TIMEOUT_DEF
)(
   input  logic        clk,
   input  logic        rstn,
   input  logic        Start,
   output logic        Busy,
   input  logic [31:0] DataOut,
   output logic [31:0] DataIn,
   input  logic [3:0]  WR,
   input  logic [15:0] ClockDiv,
   input  logic        Trans,
   output logic        SCLK,
   output logic        CSn,
   output logic        MOSI,
   input  logic        MISO
);

   localparam int TCNT_W = $clog2(RDY_TIMEOUT + CS_LEAD + CS_TRAIL + 1);

   spi_state_t        r_state, w_state_nxt;
   logic [31:0]       r_tx, w_tx_nxt;
   logic [31:0]       r_rx;
   logic [31:0]       r_data_in;
   logic [4:0]        r_bits;
   logic [15:0]       r_div, w_div_nxt;
   logic              r_trans;
   logic [TCNT_W-1:0] r_tcnt, w_tcnt_nxt;
   logic              r_csn, w_csn_nxt;
   logic              r_sclk, r_mosi;
   logic              w_accept, w_done, w_abort, w_rise, w_fall, w_tcnt_zero;
   logic              w_shift_nxt;
   logic [2:0]        w_nb;

   assign w_nb        = clamp_bytes(WR);
   assign w_accept    = (r_state == ST_IDLE) && Start && (WR != 4'd0);
   assign w_div_nxt   = w_accept ? ClockDiv : r_div;
   assign w_tcnt_zero = (r_tcnt == '0);

   cc1200_spi_clkgen u_clkgen (
      .clk     (clk),
      .rstn    (rstn),
      .i_run   ((r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI)),
      .i_phase (r_state == ST_SHIFT_HI),
      .i_div   (w_div_nxt),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_tx_nxt    = r_tx;
      w_csn_nxt   = r_csn;
      w_tcnt_nxt  = w_tcnt_zero ? r_tcnt : r_tcnt - TCNT_W'(1);
      w_done      = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_tx_nxt = align_tx(DataOut, w_nb);
               if (r_csn) begin
                  w_state_nxt = ST_CS_SETUP;
                  w_csn_nxt   = 1'b0;
                  w_tcnt_nxt  = TCNT_W'(CS_LEAD - 1);
               end else begin
                  w_state_nxt = ST_SHIFT_LO;
               end
            end
         end
         ST_CS_SETUP: begin
            if (w_tcnt_zero) begin
`ifdef CC1200_CHIP_RDY_WAIT_EN
               w_state_nxt = ST_RDY_WAIT;
               w_tcnt_nxt  = TCNT_W'(RDY_TIMEOUT - 1);
`else
               w_state_nxt = ST_SHIFT_LO;
`endif
            end
         end
`ifdef CC1200_CHIP_RDY_WAIT_EN
         ST_RDY_WAIT: begin
            if (!MISO) begin
               w_state_nxt = ST_SHIFT_LO;
            end else if (w_tcnt_zero) begin
               w_state_nxt = ST_IDLE;
               w_csn_nxt   = 1'b1;
               w_abort     = 1'b1;
            end
         end
`endif
         ST_SHIFT_LO: begin
            if (w_rise) w_state_nxt = ST_SHIFT_HI;
         end
         ST_SHIFT_HI: begin
            if (w_fall) begin
               if (r_bits != 5'd0) begin
                  w_state_nxt = ST_SHIFT_LO;
                  w_tx_nxt    = {r_tx[30:0], 1'b0};
               end else if (r_trans) begin
                  w_state_nxt = ST_IDLE;
                  w_done      = 1'b1;
               end else begin
                  w_state_nxt = ST_CS_HOLD;
                  w_tcnt_nxt  = TCNT_W'(CS_TRAIL - 1);
               end
            end
         end
         ST_CS_HOLD: begin
            if (w_tcnt_zero) begin
               w_state_nxt = ST_IDLE;
               w_csn_nxt   = 1'b1;
               w_done      = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_shift_nxt = (w_state_nxt == ST_SHIFT_LO) || (w_state_nxt == ST_SHIFT_HI);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= ST_IDLE;
         r_tx      <= 32'd0;
         r_rx      <= 32'd0;
         r_data_in <= 32'd0;
         r_bits    <= 5'd0;
         r_div     <= 16'd0;
         r_trans   <= 1'b0;
         r_tcnt    <= '0;
         r_csn     <= 1'b1;
         r_sclk    <= 1'b0;
         r_mosi    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tx    <= w_tx_nxt;
         r_tcnt  <= w_tcnt_nxt;
         r_csn   <= w_csn_nxt;
         r_sclk  <= (w_state_nxt == ST_SHIFT_HI);
         r_mosi  <= w_shift_nxt ? w_tx_nxt[31] : 1'b0;
         if (w_accept) begin
            r_div   <= ClockDiv;
            r_trans <= Trans;
            r_rx    <= 32'd0;
            // 8N-1: the 2-bit (N-1) wraps N=4 to 3, giving 31.
            r_bits  <= {w_nb[1:0] - 2'd1, 3'b111};
         end else begin
            if ((r_state == ST_SHIFT_LO) && w_rise)
               r_rx <= {r_rx[30:0], MISO};
            if ((r_state == ST_SHIFT_HI) && w_fall && (r_bits != 5'd0))
               r_bits <= r_bits - 5'd1;
         end
         if (w_done)
            r_data_in <= r_rx;
         else if (w_abort)
            r_data_in <= ABORT_DATA;
      end
   end

   assign Busy   = (r_state != ST_IDLE);
   assign DataIn = r_data_in;
   assign SCLK   = r_sclk;
   assign CSn    = r_csn;
   assign MOSI   = r_mosi;

endmodule

// File: tb/tb_cc1200_spi_master.sv
// tb_cc1200_spi_master: scoreboard bench for cc1200_spi_master (default build).
module tb_cc1200_spi_master;
   import cc1200_spi_pkg::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        Start = 1'b0;
   logic        Trans = 1'b0;
   logic [31:0] DataOut = 32'd0;
   logic [3:0]  WR = 4'd0;
   logic [15:0] ClockDiv = 16'd0;
   logic        Busy, SCLK, CSn, MOSI, MISO;
   logic [31:0] DataIn;

   always #5 clk = ~clk;

   cc1200_spi_master dut (
      .clk(clk), .rstn(rstn), .Start(Start), .Busy(Busy),
      .DataOut(DataOut), .DataIn(DataIn), .WR(WR), .ClockDiv(ClockDiv),
      .Trans(Trans), .SCLK(SCLK), .CSn(CSn), .MOSI(MOSI), .MISO(MISO)
   );

   typedef struct {
      logic [31:0] data_in;
      logic [31:0] mosi;
      int          bits;
      int          busy;
      int          period;
      logic        csn_after;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          n_vec = 0;
   int          n_mis = 0;

   // slave model: returns slv_word MSB first, advancing after each SCLK fall
   logic        loop_mode = 1'b0;
   logic        miso_bit = 1'b0;
   logic [31:0] slv_word = 32'd0;
   int          slv_msb = 7;
   bit          burst_open = 1'b0;
   assign MISO = loop_mode ? MOSI : miso_bit;

   int          cyc = 0, busy_cyc = 0, n_rise = 0, n_fall = 0;
   int          last_rise = 0, min_gap = 0, max_gap = 0;
   logic [31:0] mosi_cap = 32'd0;
   logic        prev_busy = 1'b0, prev_sclk = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: measures each transfer and checks it against the scoreboard
   always @(negedge clk) begin
      cyc++;
      if (!rstn) begin
         prev_busy = 1'b0;
         prev_sclk = 1'b0;
      end else begin
         if (Busy && !prev_busy) begin
            busy_cyc = 0; n_rise = 0; n_fall = 0; mosi_cap = 32'd0;
            min_gap = 32'h7FFF_FFFF; max_gap = 0;
         end
         if (Busy) begin
            busy_cyc++;
            if (SCLK && !prev_sclk) begin
               if (n_rise > 0) begin
                  if (cyc - last_rise < min_gap) min_gap = cyc - last_rise;
                  if (cyc - last_rise > max_gap) max_gap = cyc - last_rise;
               end
               last_rise = cyc;
               n_rise++;
               mosi_cap = {mosi_cap[30:0], MOSI};
            end
            if (!SCLK && prev_sclk) n_fall++;
         end
         if (!Busy && prev_busy) begin
            if (sb.size() == 0) begin
               n_vec++; n_mis++;
               $display("FAIL unexpected_done: got completion expected none");
            end else begin
               mon_e = sb.pop_front();
               check("datain", DataIn, mon_e.data_in);
               check("busy_cycles", busy_cyc, mon_e.busy);
               check("sclk_rises", n_rise, mon_e.bits);
               check("mosi_word", mosi_cap, mon_e.mosi);
               check("sclk_period_min", min_gap, mon_e.period);
               check("sclk_period_max", max_gap, mon_e.period);
               check("csn_after", {31'd0, CSn}, {31'd0, mon_e.csn_after});
               check("sclk_idle", {31'd0, SCLK}, 32'd0);
               check("mosi_idle", {31'd0, MOSI}, 32'd0);
            end
         end
         miso_bit = (slv_msb - n_fall >= 0) ? slv_word[slv_msb - n_fall] : 1'b0;
         prev_busy = Busy;
         prev_sclk = SCLK;
      end
   end

   task automatic wait_idle();
      for (int i = 0; i < 8000 && Busy; i++) @(negedge clk);
      if (Busy) begin
         n_vec++; n_mis++;
         $display("FAIL idle_timeout: got Busy=1 expected Busy=0");
      end
   endtask

   task automatic xfer(input logic [31:0] d, input logic [3:0] wr, input logic [15:0] div,
                       input logic tr, input logic lp, input bit poke, input logic [31:0] sw);
      int          n;
      logic [31:0] mask;
      exp_t        e;
      wait_idle();
      n    = (wr > 4'd4) ? 4 : int'(wr);
      mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
      loop_mode = lp;
      slv_word  = sw;
      slv_msb   = 8 * n - 1;
      e.data_in   = lp ? (d & mask) : (sw & mask);
      e.mosi      = d & mask;
      e.bits      = 8 * n;
      e.busy      = (burst_open ? 0 : CS_LEAD_DEF) + 16 * n * (int'(div) + 1) + (tr ? 0 : CS_TRAIL_DEF);
      e.period    = 2 * (int'(div) + 1);
      e.csn_after = !tr;
      sb.push_back(e);
      burst_open = tr;
      DataOut = d; WR = wr; ClockDiv = div; Trans = tr; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      DataOut = $urandom; WR = 4'($urandom); ClockDiv = 16'($urandom); Trans = 1'($urandom);
      if (poke) begin
         repeat (3) @(negedge clk);
         WR = 4'd3; Start = 1'b1;
         @(negedge clk);
         Start = 1'b0;
      end
   endtask

   initial begin
      logic seen_busy, seen_csn_low;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, Busy}, 32'd0);
      check("rst_datain", DataIn, 32'd0);
      check("rst_csn", {31'd0, CSn}, 32'd1);
      check("rst_sclk", {31'd0, SCLK}, 32'd0);
      check("rst_mosi", {31'd0, MOSI}, 32'd0);
      rstn = 1'b1;
      @(negedge clk);

      xfer(32'h0000_003D, 4'd1, 16'd0, 1'b0, 1'b0, 0, 32'h0000_000F);
      xfer(32'hA55A_F00F, 4'd4, 16'd3, 1'b0, 1'b1, 0, 32'd0);
      xfer(32'h0000_2F00, 4'd2, 16'd0, 1'b1, 1'b0, 0, $urandom);
      xfer(32'h0000_0012, 4'd1, 16'd0, 1'b0, 1'b0, 0, $urandom);
      wait_idle();

      // WR = 0: Start must be ignored entirely
      @(negedge clk);
      WR = 4'd0; DataOut = $urandom; Trans = 1'b0; Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      seen_busy = 1'b0; seen_csn_low = 1'b0;
      repeat (6) begin
         @(negedge clk);
         seen_busy    = seen_busy | Busy;
         seen_csn_low = seen_csn_low | ~CSn;
      end
      check("wr0_busy", {31'd0, seen_busy}, 32'd0);
      check("wr0_csn_low", {31'd0, seen_csn_low}, 32'd0);

      xfer($urandom, 4'hF, 16'd1, 1'b0, 1'b0, 1, $urandom);

      // reset in the middle of the 3rd bit
      xfer($urandom, 4'd2, 16'd1, 1'b0, 1'b0, 0, $urandom);
      for (int i = 0; i < 200 && n_fall < 2; i++) @(negedge clk);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      check("mid_rst_csn", {31'd0, CSn}, 32'd1);
      check("mid_rst_sclk", {31'd0, SCLK}, 32'd0);
      check("mid_rst_mosi", {31'd0, MOSI}, 32'd0);
      check("mid_rst_busy", {31'd0, Busy}, 32'd0);
      check("mid_rst_datain", DataIn, 32'd0);
      sb.delete();
      burst_open = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      xfer($urandom, 4'd3, 16'd2, 1'b0, 1'b0, 0, $urandom);

      for (int k = 0; k < 14; k++)
         xfer($urandom, 4'($urandom_range(1, 15)), 16'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), $urandom);
      xfer($urandom, 4'd1, 16'd0, 1'b0, 1'b0, 0, $urandom);
      wait_idle();
      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
